// File: rtl/nmea_vtg_if.sv
// Byte-stream handshake between the UART receiver and the NMEA VTG parser.
interface nmea_vtg_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/nmea_vtg_parser.sv
// Extracts ground speed in km/h (integer + tenths) from $--VTG NMEA sentences.
// Define NMEA_CHECKSUM_EN to verify the two hex checksum digits after '*'.
//
// state  | meaning
// IDLE   | waiting for '$'
// HDR    | talker/sentence ID, then the comma that opens the field list
// FIELDS | scanning comma-separated fields, accumulating km/h from field 7
// CKHI   | first checksum character after '*'
// CKLO   | second checksum character
// TERM   | waiting for CR or LF
// EMIT   | one-cycle speed update pulse, byte stream stalled
// ERR    | one-cycle discard pulse, byte stream stalled
module nmea_vtg_parser #(
  parameter int SPEED_W_P   = 10,
  parameter int SPEED_MAX_P = 999,
  parameter int MAX_LEN_P   = 82
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  nmea_vtg_if.slave            s_byte,
  output logic [SPEED_W_P-1:0] speed_kmh_o,
  output logic [3:0]           speed_tenths_o,
  output logic                 speed_valid_o,
  output logic                 sentence_err_o
);

  localparam int LEN_W = $clog2(MAX_LEN_P + 2);
  localparam int ACC_W = SPEED_W_P + 4;

  localparam logic [7:0] C_DOLLAR = 8'h24;
  localparam logic [7:0] C_COMMA  = 8'h2C;
  localparam logic [7:0] C_STAR   = 8'h2A;
  localparam logic [7:0] C_DOT    = 8'h2E;
  localparam logic [7:0] C_CR     = 8'h0D;
  localparam logic [7:0] C_LF     = 8'h0A;
  localparam logic [7:0] C_V      = 8'h56;
  localparam logic [7:0] C_T      = 8'h54;
  localparam logic [7:0] C_G      = 8'h47;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FIELDS, S_CKHI, S_CKLO, S_TERM, S_EMIT, S_ERR
  } state_t;

  state_t               r_state, w_state;
  logic [LEN_W-1:0]     r_len, w_len;
  logic [2:0]           r_hdr_cnt, w_hdr_cnt;
  logic                 r_vtg, w_vtg;
  logic [3:0]           r_field, w_field;
  logic [SPEED_W_P-1:0] r_int, w_int;
  logic [3:0]           r_tenths, w_tenths;
  logic                 r_have_int, w_have_int;
  logic                 r_dot, w_dot;
  logic                 r_have_ten, w_have_ten;
  logic [SPEED_W_P-1:0] r_speed;
  logic [3:0]           r_speed_ten;

  logic                 w_ready, w_acc, w_start, w_load;
  logic [7:0]           w_byte;
  logic                 w_is_digit, w_is_eol;
  logic [ACC_W-1:0]     w_int_calc;
  logic [SPEED_W_P-1:0] w_int_sat;

`ifdef NMEA_CHECKSUM_EN
  logic [7:0] r_xor, w_xor;
  logic [3:0] r_ck_hi, w_ck_hi;
  logic [4:0] w_hex;

  // Returns {is_hex, nibble}.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    logic [4:0] v;
    v = '0;
    if (c >= 8'h30 && c <= 8'h39)
      v = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      v = {1'b1, c[3:0] + 4'd9};
    return v;
  endfunction
`endif

  assign w_ready    = (r_state != S_EMIT) && (r_state != S_ERR);
  assign w_acc      = s_byte.valid_i && w_ready;
  assign w_byte     = s_byte.data_i;
  assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);
  assign w_is_eol   = (w_byte == C_CR) || (w_byte == C_LF);

  // Saturating decimal accumulate; the wider intermediate cannot overflow.
  assign w_int_calc = ACC_W'(r_int) * ACC_W'(10) + ACC_W'(w_byte[3:0]);
  assign w_int_sat  = (w_int_calc > ACC_W'(SPEED_MAX_P)) ? SPEED_W_P'(SPEED_MAX_P)
                                                         : w_int_calc[SPEED_W_P-1:0];

  always_comb begin
    w_state    = r_state;
    w_len      = r_len;
    w_hdr_cnt  = r_hdr_cnt;
    w_vtg      = r_vtg;
    w_field    = r_field;
    w_int      = r_int;
    w_tenths   = r_tenths;
    w_have_int = r_have_int;
    w_dot      = r_dot;
    w_have_ten = r_have_ten;
    w_start    = 1'b0;
    w_load     = 1'b0;
`ifdef NMEA_CHECKSUM_EN
    w_xor      = r_xor;
    w_ck_hi    = r_ck_hi;
    w_hex      = hex_nib(w_byte);
`endif

    case (r_state)
      S_IDLE: w_start = w_acc && (w_byte == C_DOLLAR);
      S_EMIT, S_ERR: w_state = S_IDLE;
      default: if (w_acc) begin
        w_len = r_len + 1'b1;
`ifdef NMEA_CHECKSUM_EN
        if ((r_state == S_HDR || r_state == S_FIELDS) && w_byte != C_STAR)
          w_xor = r_xor ^ w_byte;
`endif
        if (w_byte == C_DOLLAR)
          w_start = 1'b1;
        else if (w_len > LEN_W'(MAX_LEN_P))
          w_state = r_vtg ? S_ERR : S_IDLE;
        else begin
          case (r_state)
            S_HDR: begin
              w_hdr_cnt = r_hdr_cnt + 3'd1;
              if (r_hdr_cnt == 3'd5) begin
                w_field = 4'd1;
                w_state = (w_byte == C_COMMA) ? S_FIELDS : S_ERR;
              end else begin
                w_vtg = r_vtg && !((r_hdr_cnt == 3'd2 && w_byte != C_V) ||
                                   (r_hdr_cnt == 3'd3 && w_byte != C_T) ||
                                   (r_hdr_cnt == 3'd4 && w_byte != C_G));
                if (r_hdr_cnt == 3'd4 && !w_vtg)
                  w_state = S_IDLE;
              end
            end
            S_FIELDS: begin
              if (w_byte == C_COMMA) begin
                if (r_field != 4'hF) w_field = r_field + 4'd1;
              end else if (w_byte == C_STAR)
                w_state = S_CKHI;
              else if (w_is_eol)
                w_state = S_ERR;
              else if (r_field == 4'd7) begin
                if (w_is_digit && !r_dot) begin
                  w_int      = w_int_sat;
                  w_have_int = 1'b1;
                end else if (w_is_digit) begin
                  if (!r_have_ten) begin
                    w_tenths   = w_byte[3:0];
                    w_have_ten = 1'b1;
                  end
                end else if (w_byte == C_DOT && !r_dot)
                  w_dot = 1'b1;
                else
                  w_state = S_ERR;
              end
            end
            S_CKHI: begin
`ifdef NMEA_CHECKSUM_EN
              if (w_hex[4]) begin
                w_ck_hi = w_hex[3:0];
                w_state = S_CKLO;
              end else
                w_state = S_ERR;
`else
              w_state = S_CKLO;
`endif
            end
            S_CKLO: begin
`ifdef NMEA_CHECKSUM_EN
              w_state = (w_hex[4] && {r_ck_hi, w_hex[3:0]} == r_xor) ? S_TERM : S_ERR;
`else
              w_state = S_TERM;
`endif
            end
            S_TERM: if (w_is_eol) begin
              if (r_have_int) begin
                w_state = S_EMIT;
                w_load  = 1'b1;
              end else
                w_state = S_ERR;
            end
            default: ;
          endcase
        end
      end
    endcase

    // '$' always opens a fresh sentence, silently dropping any partial one.
    if (w_start) begin
      w_state    = S_HDR;
      w_len      = LEN_W'(1);
      w_hdr_cnt  = '0;
      w_vtg      = 1'b1;
      w_field    = '0;
      w_int      = '0;
      w_tenths   = '0;
      w_have_int = 1'b0;
      w_dot      = 1'b0;
      w_have_ten = 1'b0;
`ifdef NMEA_CHECKSUM_EN
      w_xor      = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_hdr_cnt  <= '0;
      r_vtg      <= 1'b0;
      r_field    <= '0;
      r_int      <= '0;
      r_tenths   <= '0;
      r_have_int <= 1'b0;
      r_dot      <= 1'b0;
      r_have_ten <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
      r_xor      <= '0;
      r_ck_hi    <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_len      <= w_len;
      r_hdr_cnt  <= w_hdr_cnt;
      r_vtg      <= w_vtg;
      r_field    <= w_field;
      r_int      <= w_int;
      r_tenths   <= w_tenths;
      r_have_int <= w_have_int;
      r_dot      <= w_dot;
      r_have_ten <= w_have_ten;
`ifdef NMEA_CHECKSUM_EN
      r_xor      <= w_xor;
      r_ck_hi    <= w_ck_hi;
`endif
    end
  end

  // Loaded on the edge that enters EMIT so value and pulse appear together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_speed     <= '0;
      r_speed_ten <= '0;
    end else if (w_load) begin
      r_speed     <= r_int;
      r_speed_ten <= r_tenths;
    end
  end

  assign s_byte.ready_o = w_ready;
  assign speed_kmh_o    = r_speed;
  assign speed_tenths_o = r_speed_ten;
  assign speed_valid_o  = (r_state == S_EMIT);
  assign sentence_err_o = (r_state == S_ERR);

endmodule

// File: tb/tb_nmea_vtg_parser.sv
// Self-checking bench for nmea_vtg_parser: directed scenarios plus random km/h fields
// checked against a string-level reference model.
module tb_nmea_vtg_parser;

  localparam int MAX_LEN = 82;

  logic       clk;
  logic       rst_n;
  logic [9:0] speed;
  logic [3:0] tenths;
  logic       spd_valid;
  logic       sent_err;

  nmea_vtg_if bif ();

  nmea_vtg_parser dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .s_byte         (bif),
    .speed_kmh_o    (speed),
    .speed_tenths_o (tenths),
    .speed_valid_o  (spd_valid),
    .sentence_err_o (sent_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nv = 0;
  int ne = 0;
  int m_speed = 0;
  int m_ten = 0;

  always @(negedge clk) begin
    if (spd_valid) nv++;
    if (sent_err) ne++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge clk);
    bif.data_i  = b;
    bif.valid_i = 1'b1;
    while (!bif.ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      tests++;
      fails++;
      $error("FAIL ready_timeout: observed ready low for %0d cycles expected under 50", t);
    end
    @(negedge clk);
    bif.valid_i = 1'b0;
  endtask

  task automatic send_str(input string s, input int gapmax);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], $urandom_range(0, gapmax));
  endtask

  function automatic logic [7:0] xor_of(input string body);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < body.len(); i++) x = x ^ body[i];
    return x;
  endfunction

  function automatic string mk(input string body, input int delta);
    logic [7:0] cs;
    cs = xor_of(body) + delta[7:0];
    return $sformatf("$%s*%02X\r\n", body, cs);
  endfunction

  function automatic string vtg_body(input string km, input int pad);
    string b;
    b = {"GPVTG,0.00,T,,M,0.00,N,", km, ",K,N"};
    for (int i = 0; i < pad; i++) b = {b, "N"};
    return b;
  endfunction

  // Reference: value of the km/h field text, decimal, capped at 999.
  function automatic void model(input string km, output bit ok, output int iv, output int tv);
    bit dot, hi, ht, bad;
    longint v;
    logic [7:0] c;
    dot = 0; hi = 0; ht = 0; bad = 0; v = 0; tv = 0;
    for (int i = 0; i < km.len(); i++) begin
      c = km[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        if (!dot) begin
          hi = 1;
          if (v < 100000) v = v * 10 + (c - 8'h30);
        end else if (!ht) begin
          ht = 1;
          tv = c - 8'h30;
        end
      end else if (c == 8'h2E && !dot) dot = 1;
      else bad = 1;
    end
    ok = hi && !bad;
    iv = (v > 999) ? 999 : int'(v);
  endfunction

  task automatic run_vtg(input string km, input int pad, input int delta, input int gapmax);
    bit    ok;
    int    iv, tv, nv0, ne0;
    string body;
    body = vtg_body(km, pad);
    model(km, ok, iv, tv);
    if (body.len() + 6 > MAX_LEN) ok = 0;
`ifdef NMEA_CHECKSUM_EN
    if (delta != 0) ok = 0;
`endif
    nv0 = nv;
    ne0 = ne;
    send_str(mk(body, delta), gapmax);
    repeat (4) @(negedge clk);
    if (ok) begin
      m_speed = iv;
      m_ten   = tv;
    end
    chk({"pulses[", km, "]"}, nv - nv0, ok ? 1 : 0);
    chk({"errs[", km, "]"}, ne - ne0, ok ? 0 : 1);
    chk({"speed[", km, "]"}, speed, m_speed);
    chk({"tenths[", km, "]"}, tenths, m_ten);
  endtask

  initial begin
    string s, km;
    int nv0, ne0, n;
    rst_n       = 1'b0;
    bif.data_i  = 8'h00;
    bif.valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_speed", speed, 0);
    chk("rst_tenths", tenths, 0);
    chk("rst_valid", spd_valid, 0);
    chk("rst_err", sent_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bif.ready_o, 1);

    // Reset in the middle of a sentence, then a clean one.
    send_str("$GPVTG,0.00,T,,M,0.00,N,12", 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_speed", speed, 0);
    chk("midrst_pulses", nv, 0);
    run_vtg("7.5", 0, 0, 0);

    // Gapped 12.00 with latency check on the CR.
    s = mk(vtg_body("12.00", 0), 0);
    nv0 = nv;
    for (int i = 0; i < s.len() - 1; i++) send_byte(s[i], $urandom_range(0, 3));
    chk("lat_valid", spd_valid, 1);
    chk("lat_ready", bif.ready_o, 0);
    chk("lat_speed", speed, 12);
    send_byte(s[s.len()-1], 0);
    repeat (4) @(negedge clk);
    m_speed = 12;
    m_ten   = 0;
    chk("gap_pulses", nv - nv0, 1);
    chk("gap_tenths", tenths, 0);

    // Other sentence types are ignored silently.
    nv0 = nv;
    ne0 = ne;
    send_str(mk("GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,", 0), 1);
    send_str(mk("GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W", 0), 1);
    repeat (4) @(negedge clk);
    chk("other_pulses", nv - nv0, 0);
    chk("other_errs", ne - ne0, 0);
    run_vtg("25.40", 0, 0, 1);

    run_vtg("1234.5", 0, 0, 0);
    run_vtg("55", 0, 0, 0);
    run_vtg("", 0, 0, 0);
    run_vtg("22.00", 0, 1, 0);

    // '$' injected mid-sentence.
    send_str("$GPVTG,0.00,T,,M,0.00,N,4", 0);
    run_vtg("23.00", 0, 0, 0);

    // Length boundary: 82 chars including CR LF is fine, 84 is discarded.
    run_vtg("9.1", 46, 0, 0);
    run_vtg("8.2", 48, 0, 0);

    for (int it = 0; it < 25; it++) begin
      km = "";
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) km = $sformatf("%s%0d", km, $urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) begin
        km = {km, "."};
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) km = $sformatf("%s%0d", km, $urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) km = {km, "x"};
      run_vtg(km, 0, 0, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
